// File: rtl/matrix_result_unloader.sv
// ============================================================================
// matrix_result_unloader : streams a captured DIMxDIM result matrix out as
// OUT_W-bit beats, row-major, MSB byte first, with valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_result_unloader #(
    parameter int ELEM_W = 16,
    parameter int OUT_W  = 8,
    parameter int DIM    = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DIM*DIM*ELEM_W-1:0] res_mat,
    input  logic                      res_valid,
    input  logic [3:0]                R,
    input  logic [3:0]                C,
    output logic                      in_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      done,
    output logic                      overrun
);

    localparam int TOT_W  = DIM * DIM * ELEM_W;
    localparam int BEATS  = ELEM_W / OUT_W;
    localparam int NBYTES = DIM * DIM * BEATS;
    localparam int CNT_W  = $clog2(DIM + 1);
    localparam int IDX_W  = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [TOT_W-1:0]    buf_mat;
    logic [CNT_W-1:0]    rows_q;
    logic [CNT_W-1:0]    cols_q;
    logic [IDX_W-1:0]    row;
    logic [IDX_W-1:0]    col;
    logic [BEAT_W-1:0]   beat;
    logic [CNT_W-1:0]    r_clamp;
    logic [CNT_W-1:0]    c_clamp;
    logic [BYTE_W-1:0]   byte_idx;
    logic                beat_last;
    logic                col_last;
    logic                row_last;
    logic                is_last;
    logic [OUT_W-1:0]    byte_arr [NBYTES];

    // Byte k of the flat buffer, counted from the MSB end.
    for (genvar k = 0; k < NBYTES; k++) begin : g_bytes
        assign byte_arr[k] = buf_mat[TOT_W-1-OUT_W*k -: OUT_W];
    end

    assign r_clamp   = (R > 4'(DIM)) ? CNT_W'(DIM) : CNT_W'(R);
    assign c_clamp   = (C > 4'(DIM)) ? CNT_W'(DIM) : CNT_W'(C);
    assign beat_last = (beat == BEAT_W'(BEATS - 1));
    assign col_last  = (CNT_W'(col) == cols_q - CNT_W'(1));
    assign row_last  = (CNT_W'(row) == rows_q - CNT_W'(1));
    assign is_last   = beat_last && col_last && row_last;
    assign byte_idx  = BYTE_W'(row) * BYTE_W'(DIM * BEATS)
                     + BYTE_W'(col) * BYTE_W'(BEATS)
                     + BYTE_W'(beat);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (res_valid) begin
                    next_state = (r_clamp == '0 || c_clamp == '0) ? S_FIN : S_SEND;
                end
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_data  = byte_arr[byte_idx];
                out_last  = is_last;
                if (out_ready && is_last) begin
                    next_state = S_FIN;
                end
            end
            S_FIN: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_mat <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
            row     <= '0;
            col     <= '0;
            beat    <= '0;
            overrun <= 1'b0;
        end else begin
            if (state == S_IDLE && res_valid) begin
                buf_mat <= res_mat;
                rows_q  <= r_clamp;
                cols_q  <= c_clamp;
                row     <= '0;
                col     <= '0;
                beat    <= '0;
            end
            if (state != S_IDLE && res_valid) begin
                overrun <= 1'b1;
            end
            // Columns beyond cols_q are never visited, which skips elements outside R x C.
            if (state == S_SEND && out_ready && !is_last) begin
                if (beat_last) begin
                    beat <= '0;
                    if (col_last) begin
                        col <= '0;
                        row <= row + IDX_W'(1);
                    end else begin
                        col <= col + IDX_W'(1);
                    end
                end else begin
                    beat <= beat + BEAT_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire
